// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side signal bundle for the direct-mapped data cache controller.
// The cache is the slave; the pipeline/memory environment is the master.
interface dcache_ctrl_if;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        hit;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, hit, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, hit, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with
// one-word lines and a single outstanding memory transaction.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | lookup; read hit answers same cycle, otherwise start miss/store
// RD_MISS | memory read outstanding, line filled on mem_ack
// WR_MEM  | memory write outstanding, line updated on mem_ack if resident
// DONE    | one-cycle result slot, returns fill register to the pipeline
module dcache_ctrl #(
  parameter int INDEX_BITS = 4
) (
  input logic         clk,
  input logic         rst,
  dcache_ctrl_if.slave bus
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_MEM, DONE} state_t;

  state_t                 state_q, state_d;
  logic [LINES-1:0]       valid_q;
  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [31:0]            data_q [LINES];
  logic [31:0]            fill_q;

  logic [INDEX_BITS-1:0]  idx;
  logic [TAG_W-1:0]       tag;
  logic                   lookup_hit;
  logic                   fill_en;
  logic                   store_done;
  logic                   store_upd;
  logic                   unused_addr_lsbs;

  logic                   hit_c;
  logic [31:0]            rdata_c;
  logic                   mem_req_c;
  logic                   mem_we_c;
  logic [31:0]            mem_addr_c;
  logic [31:0]            mem_wdata_c;

  assign idx              = bus.cpu_addr[1+INDEX_BITS:2];
  assign tag              = bus.cpu_addr[31:2+INDEX_BITS];
  assign lookup_hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign fill_en          = (state_q == RD_MISS) && bus.mem_ack;
  assign store_done       = (state_q == WR_MEM) && bus.mem_ack;
  assign store_upd        = store_done && lookup_hit;
  assign unused_addr_lsbs = ^bus.cpu_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      if (fill_en) begin
        valid_q[idx] <= 1'b1;
        fill_q       <= bus.mem_rdata;
      end else if (store_done) begin
        fill_q <= '0;
      end
    end
  end

  // Tag/data contents need no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= bus.mem_rdata;
    end else if (store_upd) begin
      data_q[idx] <= bus.cpu_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    hit_c       = 1'b0;
    rdata_c     = '0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_wr) begin
          state_d = WR_MEM;
        end else if (bus.cpu_rd) begin
          if (lookup_hit) begin
            hit_c   = 1'b1;
            rdata_c = data_q[idx];
          end else begin
            state_d = RD_MISS;
          end
        end else begin
          hit_c = 1'b1;
        end
      end
      RD_MISS: begin
        mem_req_c  = 1'b1;
        mem_addr_c = {bus.cpu_addr[31:2], 2'b00};
        if (bus.mem_ack) state_d = DONE;
      end
      WR_MEM: begin
        mem_req_c   = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = {bus.cpu_addr[31:2], 2'b00};
        mem_wdata_c = bus.cpu_wdata;
        if (bus.mem_ack) state_d = DONE;
      end
      DONE: begin
        hit_c   = 1'b1;
        rdata_c = fill_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The state register is already IDLE under reset; only the CPU view needs masking.
    if (rst) begin
      hit_c   = 1'b0;
      rdata_c = '0;
    end
  end

  assign bus.hit       = hit_c;
  assign bus.cpu_rdata = rdata_c;
  assign bus.mem_req   = mem_req_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter INDEX_BITS, default 4, line-index width (2**INDEX_BITS one-word lines); tag width = 30-INDEX_BITS.
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cpu_rd  input  1  MEM-stage load request.
REQ-005 cpu_wr  input  1  MEM-stage store request.
REQ-006 cpu_addr  input  32  byte address; bits [1:0] ignored.
REQ-007 cpu_wdata  input  32  store data.
REQ-008 cpu_rdata  output  32  load data to MEM/WB readData.
REQ-009 hit  output  1  1 = MEM-stage result valid, pipeline may advance; 0 = stall.
REQ-010 mem_req  output  1  memory request, held until mem_ack.
REQ-011 mem_we  output  1  1 = memory write, 0 = memory read.
REQ-012 mem_addr  output  32  word-aligned memory address {cpu_addr[31:2],2'b00}.
REQ-013 mem_wdata  output  32  memory write data.
REQ-014 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-015 mem_ack  input  1  one-cycle completion strobe from memory.

Function
REQ-016 Storage: direct-mapped, per line a valid bit, tag = addr[31:2+INDEX_BITS], 32-bit data; index = addr[1+INDEX_BITS:2].
REQ-017 Policy: write-through, no-write-allocate; a store updates the line only when that line is valid and its tag matches.
REQ-018 States: IDLE, RD_MISS, WR_MEM, DONE.
REQ-019 IDLE with cpu_rd=0 and cpu_wr=0: hit=1, cpu_rdata=0, no state change.
REQ-020 IDLE, cpu_rd=1, cpu_wr=0, valid and tag match: hit=1 combinationally, cpu_rdata=line data in the same cycle, state stays IDLE.
REQ-021 IDLE, cpu_rd=1, cpu_wr=0, miss: hit=0; next posedge -> RD_MISS.
REQ-022 IDLE, cpu_wr=1 (cpu_rd ignored; store wins when both set): hit=0; next posedge -> WR_MEM.
REQ-023 RD_MISS: mem_req=1, mem_we=0, hit=0; on posedge with mem_ack=1: line data<=mem_rdata, tag written, valid<=1, fill register<=mem_rdata, -> DONE.
REQ-024 WR_MEM: mem_req=1, mem_we=1, mem_wdata=cpu_wdata, hit=0; on posedge with mem_ack=1: apply REQ-017 update, -> DONE.
REQ-025 DONE: hit=1 for exactly one cycle, cpu_rdata=fill register (0 after a store), mem_req=0; the CPU request is not re-evaluated; next posedge -> IDLE.
REQ-026 mem_addr, mem_we and mem_wdata stay stable while mem_req=1; mem_ack outside RD_MISS/WR_MEM is ignored.
REQ-027 mem_addr=0, mem_wdata=0 and mem_we=0 whenever mem_req=0.
REQ-028 cpu_rd, cpu_wr, cpu_addr and cpu_wdata are held stable by the pipeline while hit=0; behaviour is undefined otherwise.
REQ-029 Minimum latencies: read hit 0 stall cycles; read miss or store 2 + memory latency cycles with hit=0 (IDLE, request, ack), then 1 DONE cycle.
REQ-030 mem_ack in the first cycle of RD_MISS/WR_MEM is legal and completes that cycle.

Reset
REQ-031 rst=1 asynchronously forces state=IDLE, all valid bits=0, fill register=0.
REQ-032 During rst=1: hit=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; line data/tag contents are don't-care.
REQ-033 Reset mid-miss or mid-store drops mem_req immediately; no line is written; a late mem_ack after reset is ignored.

Verification
REQ-034 Cold read: after reset, cpu_rd=1 addr=0x0000_0040 -> hit=0, mem_req=1 mem_we=0 mem_addr=0x40; mem_ack with mem_rdata=0xDEADBEEF -> DONE hit=1 cpu_rdata=0xDEADBEEF; repeat read -> hit=1 same cycle, no mem_req.
REQ-035 Store hit: line 0x40 valid, cpu_wr=1 addr=0x40 wdata=0x12345678 -> mem_req=1 mem_we=1 mem_wdata=0x12345678; after ack, read 0x40 -> 0x12345678 with zero stall.
REQ-036 Conflict/no-allocate: store to 0x80 (same index as 0x40 at INDEX_BITS=4, different tag) -> memory write only; read 0x40 still hits with old data; read 0x80 misses.
REQ-037 Slow memory: mem_ack delayed 5 cycles -> hit=0 and mem_addr/mem_we stable for all 5 cycles; exactly one DONE cycle follows.
REQ-038 Reset mid-miss: rst asserted in RD_MISS -> mem_req=0 immediately; mem_ack=1 one cycle after reset release has no effect; next read of same address misses.
REQ-039 Simultaneous cpu_rd=1 and cpu_wr=1 -> treated as store (mem_we=1).
